// File: rtl/stride_read_streamer_if.sv
// ---------------------------------------------------------------------------
// stride_read_streamer_if
//
// Bundles the three streaming links of the stride read streamer:
//   index_* : request indices towards the memory read port
//   rdata_* : words returned by the read port, strictly in request order
//   out_*   : forwarded words towards the PE, with a last-element tag
//
// The master modport is the streamer's view. The slave modport is the view
// of the surrounding memory port and PE.
// ---------------------------------------------------------------------------
interface stride_read_streamer_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  index_valid;
    logic                  index_ready;
    logic [WORD_WIDTH-1:0] index_data;

    logic                  rdata_valid;
    logic                  rdata_ready;
    logic [WORD_WIDTH-1:0] rdata;

    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output index_valid, index_data,
        input  index_ready,
        input  rdata_valid, rdata,
        output rdata_ready,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  index_valid, index_data,
        output index_ready,
        output rdata_valid, rdata,
        input  rdata_ready,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/stride_read_streamer.sv
// ---------------------------------------------------------------------------
// stride_read_streamer
//
// Strided read-stream engine. After a start pulse it issues the indices
// base, base+stride, ... (count of them) on the index link, collects the
// in-order returned words into a small FIFO and forwards them on the out
// link, tagging the final element. Reads in flight plus buffered words never
// exceed FIFO_DEPTH, so the FIFO cannot overflow.
//
// Ports:
//   clock, reset      clock, synchronous active-high reset
//   enable            global enable; when low every register holds
//   start             one-cycle pulse, samples base/stride/count in IDLE
//   base/stride/count stream configuration
//   busy              high while a stream with count != 0 is in progress
//   done              one-cycle completion pulse
//   quiescent         registered: idle, nothing in flight, FIFO empty
//   bus               index/rdata/out links (master modport)
// ---------------------------------------------------------------------------
module stride_read_streamer #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] base,
    input  logic [WORD_WIDTH-1:0] stride,
    input  logic [WORD_WIDTH-1:0] count,
    output logic                  busy,
    output logic                  done,
    output logic                  quiescent,
    stride_read_streamer_if.master bus
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [WORD_WIDTH-1:0] ONE_W = WORD_WIDTH'(1);
    localparam logic [PTR_W-1:0]      ONE_P = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] index_q, index_d;
    logic [WORD_WIDTH-1:0] stride_q, stride_d;
    logic [WORD_WIDTH-1:0] count_q, count_d;
    logic [WORD_WIDTH-1:0] issued_q, issued_d;
    logic [WORD_WIDTH-1:0] returned_q, returned_d;
    logic [PTR_W-1:0]      in_flight_q, in_flight_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WORD_WIDTH:0]   mem_q [FIFO_DEPTH];
    logic [WORD_WIDTH:0]   mem_d [FIFO_DEPTH];
    logic                  quiescent_q, quiescent_d;

    logic [PTR_W-1:0]      occupancy;
    logic                  fifo_empty;
    logic                  credit_ok;
    logic                  in_stream;
    logic                  index_hs;
    logic                  push;
    logic                  pop;
    logic [WORD_WIDTH:0]   head;

    // Credit: a new index may go out only if every outstanding read and
    // every buffered word still fits in the FIFO once it returns.
    assign occupancy  = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign credit_ok  = ({1'b0, in_flight_q} + {1'b0, occupancy}) < (PTR_W+1)'(FIFO_DEPTH);
    assign in_stream  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign head       = mem_q[rd_ptr_q[ADDR_W-1:0]];

    assign bus.index_valid = (state_q == S_ISSUE) && enable && credit_ok;
    assign bus.index_data  = index_q;
    assign bus.rdata_ready = enable;
    assign bus.out_valid   = !fifo_empty && enable;
    assign bus.out_data    = fifo_empty ? '0 : head[WORD_WIDTH-1:0];
    assign bus.out_last    = !fifo_empty && head[WORD_WIDTH];

    assign index_hs = bus.index_valid && bus.index_ready;
    // Returned words outside a stream are strays: accepted, never buffered.
    assign push     = bus.rdata_valid && bus.rdata_ready && in_stream;
    assign pop      = bus.out_valid && bus.out_ready;

    // A zero-length stream passes through DONE without ever reporting busy.
    assign busy      = in_stream || ((state_q == S_DONE) && (count_q != '0));
    assign done      = (state_q == S_DONE);
    assign quiescent = quiescent_q;

    // Next-state logic: FSM, index generator, counters and FIFO pointers.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        stride_d    = stride_q;
        count_d     = count_q;
        issued_d    = issued_q;
        returned_d  = returned_q;
        in_flight_d = in_flight_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        quiescent_d = (state_q == S_IDLE) && (in_flight_q == '0) && fifo_empty;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d    = base;
                    stride_d   = stride;
                    count_d    = count;
                    issued_d   = '0;
                    returned_d = '0;
                    state_d    = (count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (index_hs && (issued_q == count_q - ONE_W)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && bus.out_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (index_hs) begin
            index_d  = index_q + stride_q;
            issued_d = issued_q + ONE_W;
        end

        case ({index_hs, push})
            2'b10:   in_flight_d = in_flight_q + ONE_P;
            2'b01:   in_flight_d = in_flight_q - ONE_P;
            default: in_flight_d = in_flight_q;
        endcase

        if (push) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = {(returned_q == count_q - ONE_W), bus.rdata};
            wr_ptr_d   = wr_ptr_q + ONE_P;
            returned_d = returned_q + ONE_W;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
        end
    end

    // State registers: synchronous reset clears everything, enable low holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            returned_q  <= '0;
            in_flight_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            quiescent_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (enable) begin
            state_q     <= state_d;
            index_q     <= index_d;
            stride_q    <= stride_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            returned_q  <= returned_d;
            in_flight_q <= in_flight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            quiescent_q <= quiescent_d;
            mem_q       <= mem_d;
        end
    end
endmodule

// File: doc/stride_read_streamer.md
# stride_read_streamer

Strided read-stream engine that sits directly upstream of a memory read port. Once started, it generates the index sequence `base, base+stride, …` on the port's index link. It collects the returned words, which arrive strictly in order, and forwards them to a downstream PE-facing link with a last-element tag. Credit-based flow control bounds the reads in flight so returned data can never overflow the internal buffer.

## Interface
Parameters:
- `WORD_WIDTH`, 32, width of indices, stride, count and data.
- `FIFO_DEPTH`, 4, response buffer entries and maximum reads in flight; power of two, ≥2.

Ports:
- `clock`  in  1  positive-edge clock.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  active-high global enable; when low, all state holds.
- `start`  in  1  one-cycle pulse; loads the configuration and begins a stream.
- `base`  in  WORD_WIDTH  first index; sampled on `start`.
- `stride`  in  WORD_WIDTH  index increment, two's complement; sampled on `start`.
- `count`  in  WORD_WIDTH  number of elements; sampled on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at stream completion.
- `index_valid`  out  1  request index valid.
- `index_ready`  in  1  read port accepts the index.
- `index_data`  out  WORD_WIDTH  request index.
- `rdata_valid`  in  1  read port returns a word.
- `rdata_ready`  out  1  stream engine can take a returned word.
- `rdata`  in  WORD_WIDTH  returned word.
- `out_valid`  out  1  downstream data valid.
- `out_ready`  in  1  downstream accepts the data.
- `out_data`  out  WORD_WIDTH  forwarded word.
- `out_last`  out  1  marks the final element of the stream.
- `quiescent`  out  1  registered; high when idle, no reads in flight and the FIFO is empty.

## Operation
- FSM states and transitions:
  - IDLE: `start` with `count`≠0 → ISSUE. `start` with `count`=0 → DONE; no index is issued.
  - ISSUE: leave for DRAIN after the handshake that issues the `count`-th index.
  - DRAIN: leave for DONE after the `out` handshake that carries `out_last`.
  - DONE: `done`=1 for one cycle, then → IDLE.
- `start` is ignored outside IDLE.
- Index generation:
  - Index register is loaded with `base`.
  - On each `index_valid&&index_ready`, index += `stride`, modulo 2^WORD_WIDTH (wraps silently).
  - The issued counter is incremented on the same handshake.
- In-flight counter:
  - +1 on an index handshake.
  - −1 on `rdata_valid&&rdata_ready`.
  - Both in the same cycle leave it unchanged.
- Credit rule: `index_valid` = (state==ISSUE) && enable && (in_flight + fifo_occupancy < FIFO_DEPTH).
- `rdata_ready` = enable, constant otherwise. The credit rule guarantees FIFO space.
- FIFO:
  - Circular buffer; pointers are log2(FIFO_DEPTH)+1 bits wide and wrap.
  - Full = MSBs differ and LSBs equal.
  - A push and a pop in the same cycle when full is legal only together with a pop. By credit the FIFO is never full on a push.
  - Each entry stores the data plus a last bit. The last bit is set when the returned-word counter equals `count`−1.
- `out_valid` = FIFO non-empty && enable. `out_data` and `out_last` come from the FIFO head.
- Responses arriving in IDLE or DONE (stray) are accepted and discarded and do not change the counters.
- Reset mid-stream:
  - Returns to IDLE.
  - Clears all counters, pointers and registers.
  - Responses to earlier requests that arrive afterward are discarded as strays.

## Timing
- Reset values:
  - `busy`, `done`, `index_valid`, `out_valid`, `out_last` = 0.
  - `index_data`, `out_data` = 0.
  - `rdata_ready` = 0 while `enable` is low.
  - `quiescent` = 0 in the reset cycle, then 1 one cycle after reset is released if idle.
- `start` accepted at cycle 0:
  - `busy` and `index_valid` rise at cycle 1.
  - `index_data`=`base` at cycle 1.
- Issue rate: one index per cycle while credit remains and `index_ready`=1.
- Response accepted at cycle t → `out_valid` at cycle t+1 (registered FIFO, no bypass).
- Last `out` handshake at cycle t:
  - `done`=1 at cycle t+1.
  - `busy`=0 from cycle t+2.
- `count`=0:
  - `done` at cycle 1, `busy` never asserted.
- `enable` low:
  - All registers hold.
  - `index_valid`, `out_valid` and `rdata_ready` are forced to 0; no handshakes complete.
- `quiescent`:
  - Updates only when enable is high.
  - Lags the internal condition by one cycle.

## Test plan
- Basic stream:
  - Stimulus: base=10, stride=3, count=5; memory echoes index+100 with 2-cycle latency; out_ready=1.
  - Required response: indices 10,13,16,19,22; data 110,113,116,119,122; `out_last` only on 122; `done` one cycle after that beat.
- Credit back-pressure:
  - Stimulus: FIFO_DEPTH=4, count=10, out_ready=0.
  - Required response: exactly 4 indices issued and `index_valid` then stays 0. Raising out_ready delivers all 10 words in order, with no drop or overflow.
- Wrap and negative stride:
  - Stimulus: base=0x00000001, stride=0xFFFFFFFE (−2), count=3.
  - Required response: indices 0x1, 0xFFFFFFFF, 0xFFFFFFFD.
- Zero count and ignored restart:
  - Stimulus: count=0 → `done` at cycle 1, no `index_valid`. Then start a count=4 stream and pulse `start` again mid-stream with base=99.
  - Required response: the second pulse is ignored and the original sequence completes.
- Enable freeze:
  - Stimulus: deassert `enable` for 5 cycles mid-stream.
  - Required response: no handshakes and all state held during the freeze; the stream resumes with the correct next index and completes.
- Reset mid-stream:
  - Stimulus: assert reset with 3 reads in flight, then return those 3 responses after reset.
  - Required response: outputs are at their reset values, the responses are discarded, `out_valid` stays 0, and `quiescent`=1.
